// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, FSM encoding and GF(2^8)/column helpers
// Purpose: types and helpers imported by mix_single_column and mix_columns_iter.
// Ports: none (package).
package aes_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Column c sits at state[127-32c -: 32]; column 0 is the most significant word.
  function automatic logic [COL_W-1:0] col(input logic [STATE_W-1:0] s, input logic [1:0] c);
    logic [COL_W-1:0] r;
    case (c)
      2'd0:    r = s[127:96];
      2'd1:    r = s[95:64];
      2'd2:    r = s[63:32];
      default: r = s[31:0];
    endcase
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] put_col(input logic [STATE_W-1:0] s,
                                                 input logic [1:0] c,
                                                 input logic [COL_W-1:0] v);
    logic [STATE_W-1:0] r;
    r = s;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      default: r[31:0]   = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational AES MixColumns on one 32-bit column
// Purpose: out_r = 2*s_r ^ 3*s_(r+1) ^ s_(r+2) ^ s_(r+3), rows taken mod 4.
// Ports:
//   col_in   in  32  column, row 0 in bits [31:24]
//   col_out  out 32  mixed column, same byte order
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] s0, s1, s2, s3;
  logic [BYTE_W-1:0] x0, x1, x2, x3;

  assign {s0, s1, s2, s3} = col_in;

  assign x0 = xtime(s0);
  assign x1 = xtime(s1);
  assign x2 = xtime(s2);
  assign x3 = xtime(s3);

  // 3*b is expanded as xtime(b) ^ b, so each row needs only the four xtime results.
  assign col_out[31:24] = x0 ^ (x1 ^ s1) ^ s2 ^ s3;
  assign col_out[23:16] = s0 ^ x1 ^ (x2 ^ s2) ^ s3;
  assign col_out[15:8]  = s0 ^ s1 ^ x2 ^ (x3 ^ s3);
  assign col_out[7:0]   = (x0 ^ s0) ^ s1 ^ s2 ^ x3;

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns with valid/ready on both sides
// Purpose: mixes COLS_PER_CYCLE columns per clock (bypass when in_last=1).
// Ports:
//   clk        in  1    rising-edge clock
//   rst        in  1    synchronous active-high reset
//   in_valid   in  1    in_state/in_last valid
//   in_ready   out 1    input accepted this cycle when in_valid is high
//   in_state   in  128  ShiftRows output
//   in_last    in  1    final round: pass state through unmixed
//   out_valid  out 1    out_state valid
//   out_ready  in  1    downstream takes out_state
//   out_state  out 128  mixed or bypassed state (registered)
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // STEP truncates to 0 for four columns; col_idx then simply stays at 0.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_t               fsm, fsm_next;
  logic [1:0]         col_idx;
  logic [STATE_W-1:0] cap_state;
  logic [STATE_W-1:0] result;
  logic [STATE_W-1:0] result_next;
  logic               last;
  logic               accept;
  logic               final_group;

  logic [1:0]       idx     [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  // Taking the output and accepting the next block share one edge: no bubble.
  assign in_ready    = (fsm == IDLE) | ((fsm == DONE) & out_ready);
  assign out_valid   = (fsm == DONE);
  assign accept      = in_valid & in_ready;
  assign final_group = (fsm == BUSY) && (col_idx == LAST_IDX);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign idx[g]    = col_idx + 2'(g);
    assign col_in[g] = col(cap_state, idx[g]);
    mix_single_column u_mix (
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  always_comb begin
    result_next = result;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      result_next = put_col(result_next, idx[g], last ? col_in[g] : col_out[g]);
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE: if (accept) fsm_next = BUSY;
      BUSY: if (final_group) fsm_next = DONE;
      DONE: if (out_ready) fsm_next = in_valid ? BUSY : IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      col_idx   <= 2'd0;
      cap_state <= '0;
      result    <= '0;
      last      <= 1'b0;
      out_state <= '0;
    end else begin
      fsm <= fsm_next;
      if (accept) begin
        cap_state <= in_state;
        last      <= in_last;
        col_idx   <= 2'd0;
      end
      if (fsm == BUSY) begin
        result  <= result_next;
        col_idx <= final_group ? 2'd0 : col_idx + STEP;
        // Publish the complete block in one step so out_state never shows partial work.
        if (final_group) out_state <= result_next;
      end
    end
  end

endmodule
